// File: rtl/axis_sequence_checker_pkg.sv
// Shared definitions for the AXI-stream sequence checker: FSM state
// encoding and the constants of the optional stall LFSR.
package axis_sequence_checker_pkg;

  // SYNC waits for the first beat, TRACK compares against the expected value
  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam int unsigned LFSR_W = 16;

  // Reset seed and Galois feedback taps (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One right-shifting Galois step
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : LFSR_W'(0));
  endfunction

endpackage

// File: rtl/axis_sequence_checker_if.sv
// Stream handshake bundle feeding the sequence checker.
interface axis_sequence_checker_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;

  // Source side of the stream
  modport master (
    output idata,
    output ivalid,
    input  iready
  );

  // Checker side of the stream
  modport slave (
    input  idata,
    input  ivalid,
    output iready
  );

endinterface

// File: rtl/axis_sequence_checker_lfsr16.sv
// Free-running 16-bit Galois LFSR used to throttle iready when the stall
// feature is compiled in.
module lfsr16
  import axis_sequence_checker_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] value
);

  // Seed on reset, otherwise advance one step per enabled cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (enable) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/axis_sequence_checker.sv
// Checks that an incoming stream carries consecutive values (x, x+1, ...),
// reporting mismatches with a one-cycle error pulse and saturating counter.
// Optional feature: define AXIS_SEQUENCE_CHECKER_STALL_EN to throttle iready
// with a free-running LFSR (ready only when its STALL_MASK low bits are 0).
module axis_sequence_checker
  import axis_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CWIDTH     = 16,
  parameter int unsigned STALL_MASK = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  axis_sequence_checker_if.slave s_axis,
  output logic [WIDTH-1:0]       last_data,
  output logic                   locked,
  output logic                   error,
  output logic [CWIDTH-1:0]      error_count,
  output logic [CWIDTH-1:0]      beat_count
);

  // The stall mask selects low LFSR bits, so it cannot exceed the LFSR width
  if (STALL_MASK > LFSR_W) begin : g_mask_check
    $error("STALL_MASK must not exceed the LFSR width");
  end

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] expected_d;
  logic             iready_q;
  logic             iready_d;
  logic             accept_c;
  logic             mismatch_c;

  assign accept_c      = s_axis.ivalid & iready_q;
  assign s_axis.iready = iready_q;

`ifdef AXIS_SEQUENCE_CHECKER_STALL_EN
  localparam logic [LFSR_W-1:0] STALL_BITS = LFSR_W'((32'd1 << STALL_MASK) - 32'd1);

  logic [LFSR_W-1:0] lfsr_value;

  lfsr16 u_lfsr16 (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .value  (lfsr_value)
  );

  // Ready for the next cycle only when the selected LFSR bits are all zero
  assign iready_d = ((lfsr_value & STALL_BITS) == LFSR_W'(0));
`else
  // Without throttling the checker is always ready once out of reset
  assign iready_d = 1'b1;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accepted beat leaves SYNC, TRACK is never left
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (accept_c) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = SYNC;
    endcase
  end

  // Per-beat decisions: next expected value and whether the beat mismatched
  always_comb begin
    expected_d = expected_q;
    mismatch_c = 1'b0;
    if (accept_c) begin
      expected_d = s_axis.idata + WIDTH'(1);
      if ((state_q == TRACK) && (s_axis.idata != expected_q)) begin
        mismatch_c = 1'b1;
      end
    end
  end

  // Registered outputs and tracking state, updated the cycle after acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      expected_q  <= '0;
      iready_q    <= 1'b0;
      last_data   <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
      beat_count  <= '0;
    end else begin
      iready_q <= iready_d;
      error    <= mismatch_c;
      if (accept_c) begin
        expected_q <= expected_d;
        last_data  <= s_axis.idata;
        locked     <= 1'b1;
        beat_count <= beat_count + CWIDTH'(1);
        if (mismatch_c && (error_count != {CWIDTH{1'b1}})) begin
          error_count <= error_count + CWIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_sequence_checker.sv
// Bench for axis_sequence_checker: two instances (16-bit and 2-bit counters)
// share one stream; a behavioural model tracks the expected results.
`timescale 1ns/1ps
module tb_axis_sequence_checker;
  import axis_sequence_checker_pkg::*;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CW       = 16;
  localparam int unsigned CWS      = 2;
  localparam int unsigned SMASK    = 3;
  localparam int unsigned WAIT_MAX = 200;
  localparam logic [15:0] SBITS    = 16'((32'd1 << SMASK) - 32'd1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axis_sequence_checker_if #(.WIDTH(WIDTH)) ifa ();
  axis_sequence_checker_if #(.WIDTH(WIDTH)) ifb ();
  assign ifb.idata  = ifa.idata;
  assign ifb.ivalid = ifa.ivalid;

  logic [WIDTH-1:0] la_last, lb_last;
  logic             la_locked, lb_locked, la_err, lb_err;
  logic [CW-1:0]    la_ecnt, la_bcnt;
  logic [CWS-1:0]   lb_ecnt, lb_bcnt;

  axis_sequence_checker #(.WIDTH(WIDTH), .CWIDTH(CW), .STALL_MASK(SMASK)) dut (
    .clock(clock), .reset(reset), .s_axis(ifa),
    .last_data(la_last), .locked(la_locked), .error(la_err),
    .error_count(la_ecnt), .beat_count(la_bcnt)
  );

  axis_sequence_checker #(.WIDTH(WIDTH), .CWIDTH(CWS), .STALL_MASK(SMASK)) dut_small (
    .clock(clock), .reset(reset), .s_axis(ifb),
    .last_data(lb_last), .locked(lb_locked), .error(lb_err),
    .error_count(lb_ecnt), .beat_count(lb_bcnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: previous accepted value, plain integer counts
  bit         m_have;
  logic [7:0] m_prev;
  int         m_beats;
  int         m_errs;
  bit         m_pulse;

  function automatic void model_reset();
    m_have = 0; m_prev = 8'h00; m_beats = 0; m_errs = 0; m_pulse = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] d);
    m_pulse = m_have && (d != 8'(m_prev + 8'd1));
    if (m_pulse) m_errs++;
    m_have = 1;
    m_prev = d;
    m_beats++;
  endfunction

  function automatic logic [CW-1:0] exp_ecnt();
    return (m_errs > 65535) ? 16'hFFFF : CW'(m_errs);
  endfunction

  function automatic logic [CWS-1:0] exp_secnt();
    return (m_errs > 3) ? 2'd3 : CWS'(m_errs);
  endfunction

  function automatic logic [15:0] lf_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  task automatic do_reset(input logic v, input logic [7:0] d);
    ifa.ivalid = v; ifa.idata = d; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ifa.ivalid = 1'b0;
    model_reset();
  endtask

  // Present one beat and wait (bounded) until it is accepted
  task automatic send(input logic [7:0] d, output logic err_a, output logic err_b);
    int n = 0;
    ifa.idata = d; ifa.ivalid = 1'b1;
    while (ifa.iready !== 1'b1 && n < WAIT_MAX) begin
      @(posedge clock); #1; n++;
    end
    if (n >= WAIT_MAX) begin
      total++; bad++;
      $display("FAIL send_timeout: iready=%b, required 1 within %0d cycles", ifa.iready, WAIT_MAX);
    end
    @(posedge clock); #1;
    model_accept(d);
    err_a = la_err; err_b = lb_err;
  endtask

  task automatic test_reset();
    logic exp_rdy;
    do_reset(1'b0, 8'h00);
    total++; if (ifa.iready !== 1'b0) begin bad++; $display("FAIL reset_iready: got %b required 0", ifa.iready); end
    total++; if ({la_locked, la_err, la_last} !== 10'd0) begin bad++; $display("FAIL reset_flags: locked=%b error=%b last=%h required 0", la_locked, la_err, la_last); end
    total++; if ({la_ecnt, la_bcnt} !== 32'd0) begin bad++; $display("FAIL reset_counts: ecnt=%0d bcnt=%0d required 0", la_ecnt, la_bcnt); end
    total++; if ({lb_locked, lb_err, lb_ecnt, lb_bcnt, lb_last} !== 14'd0) begin bad++; $display("FAIL reset_small: locked=%b err=%b ecnt=%0d bcnt=%0d last=%h required 0", lb_locked, lb_err, lb_ecnt, lb_bcnt, lb_last); end
    @(posedge clock); #1;
`ifdef AXIS_SEQUENCE_CHECKER_STALL_EN
    exp_rdy = ((LFSR_SEED & SBITS) == 16'h0000);
`else
    exp_rdy = 1'b1;
`endif
    total++; if (ifa.iready !== exp_rdy) begin bad++; $display("FAIL reset_iready_rise: got %b required %b", ifa.iready, exp_rdy); end
  endtask

  task automatic test_increment();
    logic ea, eb;
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h05 + i), ea, eb);
      total++; if (ea !== 1'b0 || eb !== 1'b0) begin bad++; $display("FAIL inc_error beat %0d: got %b/%b required 0", i, ea, eb); end
      total++; if (la_locked !== 1'b1) begin bad++; $display("FAIL inc_locked beat %0d: got %b required 1", i, la_locked); end
    end
    ifa.ivalid = 1'b0;
    total++; if (la_bcnt !== 16'd6) begin bad++; $display("FAIL inc_beat_count: got %0d required 6", la_bcnt); end
    total++; if (la_last !== 8'h0A) begin bad++; $display("FAIL inc_last_data: got %h required 0a", la_last); end
    total++; if (la_ecnt !== 16'd0) begin bad++; $display("FAIL inc_error_count: got %0d required 0", la_ecnt); end
  endtask

  task automatic test_wrap();
    logic ea, eb;
    logic [7:0] seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(seq[i], ea, eb);
      total++; if (ea !== 1'b0 || eb !== 1'b0) begin bad++; $display("FAIL wrap_error beat %0d: got %b/%b required 0", i, ea, eb); end
    end
    ifa.ivalid = 1'b0;
    total++; if (la_bcnt !== 16'd4) begin bad++; $display("FAIL wrap_beat_count: got %0d required 4", la_bcnt); end
    total++; if (la_ecnt !== 16'd0) begin bad++; $display("FAIL wrap_error_count: got %0d required 0", la_ecnt); end
  endtask

  task automatic test_mismatch();
    logic ea, eb;
    logic [7:0] seq [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(seq[i], ea, eb);
      total++; if (ea !== (i == 2) || eb !== (i == 2)) begin bad++; $display("FAIL mismatch_pulse beat %0d: got %b/%b required %b", i, ea, eb, (i == 2)); end
    end
    ifa.ivalid = 1'b0;
    total++; if (la_ecnt !== 16'd1 || lb_ecnt !== 2'd1) begin bad++; $display("FAIL mismatch_count: got %0d/%0d required 1", la_ecnt, lb_ecnt); end
    @(posedge clock); #1;
    total++; if (la_err !== 1'b0) begin bad++; $display("FAIL mismatch_idle_error: got %b required 0", la_err); end
  endtask

  task automatic test_saturate();
    logic ea, eb;
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      send(8'(i * 5), ea, eb);
      total++; if (ea !== (i > 0) || eb !== (i > 0)) begin bad++; $display("FAIL sat_pulse beat %0d: got %b/%b required %b", i, ea, eb, (i > 0)); end
      total++; if (lb_bcnt !== 2'(i + 1)) begin bad++; $display("FAIL sat_small_beat_count beat %0d: got %0d required %0d", i, lb_bcnt, 2'(i + 1)); end
    end
    ifa.ivalid = 1'b0;
    total++; if (lb_ecnt !== 2'd3) begin bad++; $display("FAIL sat_small_error_count: got %0d required 3", lb_ecnt); end
    total++; if (la_ecnt !== 16'd5) begin bad++; $display("FAIL sat_error_count: got %0d required 5", la_ecnt); end
    total++; if (la_bcnt !== 16'd6) begin bad++; $display("FAIL sat_beat_count: got %0d required 6", la_bcnt); end
  endtask

  task automatic test_random();
    logic ea, eb;
    logic [7:0] d;
    int gap;
    do_reset(1'b0, 8'h00);
    d = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(d + 8'd1);
      send(d, ea, eb);
      total++; if (ea !== m_pulse || eb !== m_pulse) begin bad++; $display("FAIL rand_pulse beat %0d data %h: got %b/%b required %b", i, d, ea, eb, m_pulse); end
      total++; if (la_ecnt !== exp_ecnt() || lb_ecnt !== exp_secnt()) begin bad++; $display("FAIL rand_error_count beat %0d: got %0d/%0d required %0d/%0d", i, la_ecnt, lb_ecnt, exp_ecnt(), exp_secnt()); end
      total++; if (la_bcnt !== CW'(m_beats) || lb_bcnt !== CWS'(m_beats) || la_last !== d) begin bad++; $display("FAIL rand_beat beat %0d: bcnt=%0d/%0d last=%h required %0d/%0d %h", i, la_bcnt, lb_bcnt, la_last, CW'(m_beats), CWS'(m_beats), d); end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        ifa.ivalid = 1'b0;
        repeat (gap) begin
          @(posedge clock); #1;
          total++; if (la_err !== 1'b0 || la_bcnt !== CW'(m_beats)) begin bad++; $display("FAIL rand_idle beat %0d: error=%b bcnt=%0d required 0 %0d", i, la_err, la_bcnt, CW'(m_beats)); end
        end
      end
    end
    ifa.ivalid = 1'b0;
  endtask

  // ivalid held high; data advances only when a beat is accepted
  task automatic test_stall();
    logic [15:0] lf;
    logic [7:0]  d;
    logic        rdy_prev, exp_rdy;
    do_reset(1'b0, 8'h00);
    lf = LFSR_SEED; d = 8'h30; rdy_prev = 1'b0;
    ifa.idata = d; ifa.ivalid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock); #1;
      if (rdy_prev) begin model_accept(d); d = 8'(d + 8'd1); end
`ifdef AXIS_SEQUENCE_CHECKER_STALL_EN
      exp_rdy = ((lf & SBITS) == 16'h0000);
`else
      exp_rdy = 1'b1;
`endif
      lf = lf_step(lf);
      total++; if (ifa.iready !== exp_rdy) begin bad++; $display("FAIL stall_iready cycle %0d: got %b required %b", k, ifa.iready, exp_rdy); end
      total++; if (la_err !== 1'b0 || la_bcnt !== CW'(m_beats)) begin bad++; $display("FAIL stall_stream cycle %0d: error=%b bcnt=%0d required 0 %0d", k, la_err, la_bcnt, CW'(m_beats)); end
      if (m_beats > 0) begin
        total++; if (la_last !== 8'(d - 8'd1)) begin bad++; $display("FAIL stall_last cycle %0d: got %h required %h", k, la_last, 8'(d - 8'd1)); end
      end
      rdy_prev = exp_rdy;
      ifa.idata = d;
    end
    ifa.ivalid = 1'b0;
    total++; if (m_beats == 0 || la_ecnt !== 16'd0) begin bad++; $display("FAIL stall_summary: beats=%0d ecnt=%0d required >0 and 0", m_beats, la_ecnt); end
  endtask

  task automatic test_midreset();
    logic ea, eb;
    do_reset(1'b0, 8'h00);
    send(8'h50, ea, eb);
    send(8'h51, ea, eb);
    send(8'h60, ea, eb);
    total++; if (ea !== 1'b1 || la_ecnt !== 16'd1) begin bad++; $display("FAIL midreset_setup: error=%b ecnt=%0d required 1 1", ea, la_ecnt); end
    do_reset(1'b1, 8'h61);
    total++; if ({ifa.iready, la_locked, la_err} !== 3'b000) begin bad++; $display("FAIL midreset_flags: iready=%b locked=%b error=%b required 0", ifa.iready, la_locked, la_err); end
    total++; if ({la_ecnt, la_bcnt, la_last} !== 40'd0) begin bad++; $display("FAIL midreset_regs: ecnt=%0d bcnt=%0d last=%h required 0", la_ecnt, la_bcnt, la_last); end
    total++; if ({lb_ecnt, lb_bcnt} !== 4'd0) begin bad++; $display("FAIL midreset_small: ecnt=%0d bcnt=%0d required 0", lb_ecnt, lb_bcnt); end
    send(8'h99, ea, eb);
    ifa.ivalid = 1'b0;
    total++; if (ea !== 1'b0 || eb !== 1'b0) begin bad++; $display("FAIL midreset_sync_error: got %b/%b required 0", ea, eb); end
    total++; if (la_locked !== 1'b1 || la_bcnt !== 16'd1 || la_last !== 8'h99) begin bad++; $display("FAIL midreset_first_beat: locked=%b bcnt=%0d last=%h required 1 1 99", la_locked, la_bcnt, la_last); end
  endtask

  initial begin
    reset = 1'b1; ifa.ivalid = 1'b0; ifa.idata = 8'h00;
    model_reset();
    test_reset();
    test_increment();
    test_wrap();
    test_mismatch();
    test_saturate();
    test_random();
    test_stall();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
